// File: rtl/image_transfer_packer.sv
// image_transfer_packer: packs a push-only pixel stream into LANES-wide beats,
// queues them in a DEPTH-entry FIFO, and presents them on a valid/ready stream.
//
// Output handshake: a beat is transferred on every rising edge where
// ul1OutValid && ul1OutReady. While ul1OutValid is high and ul1OutReady is
// low, the beat and all of its side-band fields hold stable. The input side has
// no backpressure. A beat that arrives while the FIFO is full and not being
// popped is dropped and flagged.
module image_transfer_packer #(
    parameter int PIXEL_W   = 24,
    parameter int LANES     = 4,
    parameter int DEPTH     = 16,
    parameter int MB_TYPE_W = 2
) (
    input  logic                         ul1Clock,
    input  logic                         ul1Reset,
    input  logic                         ul1InActive,
    input  logic [MB_TYPE_W-1:0]         ulInMbType,
    input  logic [PIXEL_W-1:0]           ulInPixel,
    input  logic                         ul1InMbEnd,
    output logic                         ul1OutValid,
    input  logic                         ul1OutReady,
    output logic [LANES*PIXEL_W-1:0]     ulOutData,
    output logic [LANES-1:0]             ulOutLaneMask,
    output logic [MB_TYPE_W-1:0]         ulOutMbType,
    output logic                         ul1OutMbEnd,
    output logic [$clog2(DEPTH):0]       ulFillLevel,
    output logic                         ul1Overflow,
    output logic                         ul1ProtocolError
);

    localparam int CNT_W  = $clog2(LANES);
    localparam int AW     = $clog2(DEPTH);
    localparam int FILL_W = AW + 1;
    localparam int BEAT_W = LANES * PIXEL_W;

    localparam logic [CNT_W-1:0]  LAST_LANE  = CNT_W'(LANES - 1);
    localparam logic [FILL_W-1:0] FULL_LEVEL = FILL_W'(DEPTH);

    // Packer state: the beat under construction.
    logic [CNT_W-1:0]     lane_cnt;
    logic [BEAT_W-1:0]    part_data;
    logic [LANES-1:0]     part_mask;
    logic [MB_TYPE_W-1:0] beat_type;

    // Packer next-state and the beat offered to the FIFO this cycle.
    logic [CNT_W-1:0]     nxt_cnt;
    logic [BEAT_W-1:0]    nxt_data;
    logic [LANES-1:0]     nxt_mask;
    logic [MB_TYPE_W-1:0] nxt_type;
    logic                 beat_push;
    logic                 beat_end;
    logic                 type_err;

    // FIFO storage and bookkeeping.
    logic [BEAT_W-1:0]    mem_data [DEPTH];
    logic [LANES-1:0]     mem_mask [DEPTH];
    logic [MB_TYPE_W-1:0] mem_type [DEPTH];
    logic                 mem_end  [DEPTH];
    logic [AW-1:0]        rd_ptr;
    logic [AW-1:0]        wr_ptr;
    logic [FILL_W-1:0]    fill;
    logic                 overflow;
    logic                 protocol_error;

    logic                 out_valid;
    logic                 pop;
    logic                 full;
    logic                 wr_en;
    logic                 drop;

    // Place the incoming pixel into its lane and decide whether a beat closes.
    always_comb begin
        nxt_cnt   = lane_cnt;
        nxt_data  = part_data;
        nxt_mask  = part_mask;
        nxt_type  = beat_type;
        beat_push = 1'b0;
        beat_end  = 1'b0;
        type_err  = 1'b0;
        if (ul1InActive) begin
            if (lane_cnt == '0) begin
                nxt_type = ulInMbType;
            end else if (ulInMbType != beat_type) begin
                // Pixel is still packed; the beat keeps its latched type.
                type_err = 1'b1;
            end
            for (int i = 0; i < LANES; i++) begin
                if (CNT_W'(i) == lane_cnt) begin
                    nxt_data[i*PIXEL_W +: PIXEL_W] = ulInPixel;
                    nxt_mask[i]                    = 1'b1;
                end
            end
            if (lane_cnt == LAST_LANE || ul1InMbEnd) begin
                beat_push = 1'b1;
                beat_end  = ul1InMbEnd;
            end else begin
                nxt_cnt = lane_cnt + CNT_W'(1);
            end
        end else if (lane_cnt != '0) begin
            // Active dropped mid-beat: flush what we have, not a macroblock end.
            beat_push = 1'b1;
        end
    end

    // Packer registers; a closed beat (written or dropped) restarts at lane 0
    // with cleared data so unused lanes of the next partial beat read as zero.
    always_ff @(posedge ul1Clock) begin
        if (ul1Reset) begin
            lane_cnt  <= '0;
            part_data <= '0;
            part_mask <= '0;
            beat_type <= '0;
        end else if (beat_push) begin
            lane_cnt  <= '0;
            part_data <= '0;
            part_mask <= '0;
            beat_type <= nxt_type;
        end else begin
            lane_cnt  <= nxt_cnt;
            part_data <= nxt_data;
            part_mask <= nxt_mask;
            beat_type <= nxt_type;
        end
    end

    assign out_valid = (fill != '0);
    assign pop       = out_valid && ul1OutReady;
    assign full      = (fill == FULL_LEVEL);
    // A full FIFO still takes a beat when the head leaves on the same edge.
    assign wr_en     = beat_push && (!full || pop);
    assign drop      = beat_push && !wr_en;

    // FIFO storage write; contents need no reset because fill gates visibility.
    always_ff @(posedge ul1Clock) begin
        if (!ul1Reset && wr_en) begin
            mem_data[wr_ptr] <= nxt_data;
            mem_mask[wr_ptr] <= nxt_mask;
            mem_type[wr_ptr] <= nxt_type;
            mem_end[wr_ptr]  <= beat_end;
        end
    end

    // FIFO pointers, fill level and sticky error flags.
    always_ff @(posedge ul1Clock) begin
        if (ul1Reset) begin
            rd_ptr         <= '0;
            wr_ptr         <= '0;
            fill           <= '0;
            overflow       <= 1'b0;
            protocol_error <= 1'b0;
        end else begin
            if (wr_en) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({wr_en, pop})
                2'b10:   fill <= fill + FILL_W'(1);
                2'b01:   fill <= fill - FILL_W'(1);
                default: fill <= fill;
            endcase
            if (drop) begin
                overflow <= 1'b1;
            end
            if (type_err) begin
                protocol_error <= 1'b1;
            end
        end
    end

    // Head of the FIFO drives the outputs directly; everything reads 0 when empty.
    always_comb begin
        ul1OutValid   = out_valid;
        ulOutData     = '0;
        ulOutLaneMask = '0;
        ulOutMbType   = '0;
        ul1OutMbEnd   = 1'b0;
        if (out_valid) begin
            ulOutData     = mem_data[rd_ptr];
            ulOutLaneMask = mem_mask[rd_ptr];
            ulOutMbType   = mem_type[rd_ptr];
            ul1OutMbEnd   = mem_end[rd_ptr];
        end
        ulFillLevel      = fill;
        ul1Overflow      = overflow;
        ul1ProtocolError = protocol_error;
    end

endmodule

// File: tb/tb_image_transfer_packer.sv
// Testbench for image_transfer_packer: directed scenarios plus random traffic,
// checked against a queue-based reference model by a separate output monitor.
module tb_image_transfer_packer;

  localparam int PIXEL_W   = 24;
  localparam int LANES     = 4;
  localparam int DEPTH     = 16;
  localparam int MB_TYPE_W = 2;
  localparam int FILL_W    = $clog2(DEPTH) + 1;
  localparam int BEAT_W    = LANES * PIXEL_W;
  localparam int W         = 1 + MB_TYPE_W + LANES + BEAT_W;

  logic                     ul1Clock;
  logic                     ul1Reset;
  logic                     ul1InActive;
  logic [MB_TYPE_W-1:0]     ulInMbType;
  logic [PIXEL_W-1:0]       ulInPixel;
  logic                     ul1InMbEnd;
  logic                     ul1OutValid;
  logic                     ul1OutReady;
  logic [BEAT_W-1:0]        ulOutData;
  logic [LANES-1:0]         ulOutLaneMask;
  logic [MB_TYPE_W-1:0]     ulOutMbType;
  logic                     ul1OutMbEnd;
  logic [FILL_W-1:0]        ulFillLevel;
  logic                     ul1Overflow;
  logic                     ul1ProtocolError;

  image_transfer_packer #(
    .PIXEL_W(PIXEL_W), .LANES(LANES), .DEPTH(DEPTH), .MB_TYPE_W(MB_TYPE_W)
  ) dut (
    .ul1Clock(ul1Clock), .ul1Reset(ul1Reset), .ul1InActive(ul1InActive),
    .ulInMbType(ulInMbType), .ulInPixel(ulInPixel), .ul1InMbEnd(ul1InMbEnd),
    .ul1OutValid(ul1OutValid), .ul1OutReady(ul1OutReady), .ulOutData(ulOutData),
    .ulOutLaneMask(ulOutLaneMask), .ulOutMbType(ulOutMbType),
    .ul1OutMbEnd(ul1OutMbEnd), .ulFillLevel(ulFillLevel),
    .ul1Overflow(ul1Overflow), .ul1ProtocolError(ul1ProtocolError)
  );

  // ---------------- clock ----------------
  initial ul1Clock = 1'b0;
  always #5 ul1Clock = ~ul1Clock;

  // ---------------- scoreboard state ----------------
  logic [W-1:0]         exp_q[$];
  logic [PIXEL_W-1:0]   cur_q[$];
  logic [MB_TYPE_W-1:0] cur_type;
  logic                 exp_ovf;
  logic                 exp_perr;
  int                   n_pass;
  int                   n_chk;

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Close the pixels collected so far into an expected beat.
  task automatic emit(input logic mb_end);
    logic [BEAT_W-1:0] d;
    logic [LANES-1:0]  m;
    d = '0;
    m = '0;
    for (int i = 0; i < cur_q.size(); i++) begin
      d[i*PIXEL_W +: PIXEL_W] = cur_q[i];
      m[i] = 1'b1;
    end
    // The monitor has already retired any beat leaving on this edge.
    if (exp_q.size() < DEPTH) exp_q.push_back({mb_end, cur_type, m, d});
    else exp_ovf = 1'b1;
    cur_q.delete();
  endtask

  // Reference model: evaluates the inputs seen by each rising edge.
  initial begin
    exp_ovf  = 1'b0;
    exp_perr = 1'b0;
    cur_type = '0;
    forever begin
      @(posedge ul1Clock);
      if (ul1Reset) begin
        exp_q.delete();
        cur_q.delete();
        exp_ovf  = 1'b0;
        exp_perr = 1'b0;
      end else if (ul1InActive) begin
        if (cur_q.size() == 0) cur_type = ulInMbType;
        else if (ulInMbType != cur_type) exp_perr = 1'b1;
        cur_q.push_back(ulInPixel);
        if (cur_q.size() == LANES || ul1InMbEnd) emit(ul1InMbEnd);
      end else if (cur_q.size() > 0) begin
        emit(1'b0);
      end
    end
  end

  // Monitor: at each falling edge compare status and retire accepted beats.
  initial begin
    logic         stall_prev;
    logic [W-1:0] held;
    logic [W-1:0] got;
    stall_prev = 1'b0;
    held = '0;
    forever begin
      @(negedge ul1Clock);
      got = {ul1OutMbEnd, ulOutMbType, ulOutLaneMask, ulOutData};
      chk("fill_level", W'(ulFillLevel), W'(exp_q.size()));
      chk("out_valid", W'(ul1OutValid), W'(exp_q.size() != 0));
      chk("overflow", W'(ul1Overflow), W'(exp_ovf));
      chk("protocol_error", W'(ul1ProtocolError), W'(exp_perr));
      if (stall_prev) chk("stall_stable", got, held);
      if (ul1OutValid && ul1OutReady) begin
        if (exp_q.size() == 0) chk("unexpected_beat", got, '0);
        else chk("beat", got, exp_q.pop_front());
      end
      stall_prev = ul1OutValid && !ul1OutReady && !ul1Reset;
      held = got;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step(input logic a, input logic [MB_TYPE_W-1:0] t,
                      input logic [PIXEL_W-1:0] p, input logic e);
    ul1InActive = a;
    ulInMbType  = t;
    ulInPixel   = p;
    ul1InMbEnd  = e;
    @(posedge ul1Clock);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, '0, '0, 1'b0);
  endtask

  task automatic do_reset();
    ul1Reset = 1'b1;
    idle(2);
    ul1Reset = 1'b0;
  endtask

  task automatic chk_all_zero(input string name);
    chk({name, "_valid"}, W'(ul1OutValid), '0);
    chk({name, "_out"}, {ul1OutMbEnd, ulOutMbType, ulOutLaneMask, ulOutData}, '0);
    chk({name, "_fill"}, W'(ulFillLevel), '0);
    chk({name, "_flags"}, W'({ul1Overflow, ul1ProtocolError}), '0);
  endtask

  task automatic drain();
    int budget;
    ul1OutReady = 1'b1;
    budget = 0;
    while (ulFillLevel != 0 && budget < 200) begin
      idle(1);
      budget++;
    end
    chk("drain_empty", W'(ulFillLevel), '0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [MB_TYPE_W-1:0] rt;
    n_pass = 0;
    n_chk  = 0;
    ul1Reset    = 1'b1;
    ul1OutReady = 1'b0;
    ul1InActive = 1'b0;
    ulInMbType  = '0;
    ulInPixel   = '0;
    ul1InMbEnd  = 1'b0;
    do_reset();
    chk_all_zero("after_reset");

    // Two full beats, macroblock end on the eighth pixel.
    ul1OutReady = 1'b1;
    for (int i = 1; i <= 8; i++) step(1'b1, 2'd0, PIXEL_W'(i), i == 8);
    idle(3);

    // Partial beat closed by macroblock end, then flush on active drop.
    for (int i = 1; i <= 6; i++) step(1'b1, 2'd1, PIXEL_W'(16 + i), i == 6);
    for (int i = 1; i <= 3; i++) step(1'b1, 2'd2, PIXEL_W'(32 + i), 1'b0);
    idle(3);

    // Fill to DEPTH with ready low; the seventeenth beat is dropped.
    ul1OutReady = 1'b0;
    for (int i = 1; i <= 68; i++) step(1'b1, 2'd0, PIXEL_W'(256 + i), 1'b0);
    idle(1);
    chk("full_level", W'(ulFillLevel), W'(DEPTH));
    chk("overflow_set", W'(ul1Overflow), W'(1));
    drain();

    // Full FIFO, pop and write on the same edge: accepted, no overflow.
    do_reset();
    ul1OutReady = 1'b0;
    for (int i = 1; i <= 64; i++) step(1'b1, 2'd3, PIXEL_W'(512 + i), 1'b0);
    for (int i = 1; i <= 3; i++) step(1'b1, 2'd3, PIXEL_W'(600 + i), 1'b0);
    ul1OutReady = 1'b1;
    step(1'b1, 2'd3, PIXEL_W'(604), 1'b0);
    ul1OutReady = 1'b0;
    chk("pop_push_full_level", W'(ulFillLevel), W'(DEPTH));
    chk("pop_push_no_overflow", W'(ul1Overflow), '0);
    drain();

    // Type change mid-beat: error flag, beat keeps the first type.
    do_reset();
    ul1OutReady = 1'b0;
    step(1'b1, 2'd1, 24'hAAAAAA, 1'b0);
    step(1'b1, 2'd2, 24'hBBBBBB, 1'b0);
    idle(1);
    chk("perr_set", W'(ul1ProtocolError), W'(1));
    chk("perr_beat_type", W'(ulOutMbType), W'(1));
    chk("perr_beat_mask", W'(ulOutLaneMask), W'(4'h3));
    drain();

    // Random traffic with random backpressure.
    do_reset();
    rt = '0;
    for (int i = 0; i < 1500; i++) begin
      ul1OutReady = ($urandom_range(0, 99) < 60);
      if ($urandom_range(0, 99) < 3) rt = MB_TYPE_W'($urandom_range(0, 3));
      step($urandom_range(0, 99) < 75, rt, PIXEL_W'($urandom), $urandom_range(0, 99) < 12);
    end
    drain();

    // Reset mid-macroblock with five beats queued and two lanes pending.
    do_reset();
    ul1OutReady = 1'b0;
    for (int i = 1; i <= 22; i++) step(1'b1, 2'd2, PIXEL_W'(1024 + i), 1'b0);
    chk("pre_reset_fill", W'(ulFillLevel), W'(5));
    ul1Reset = 1'b1;
    idle(1);
    ul1Reset = 1'b0;
    chk_all_zero("mid_reset");
    ul1OutReady = 1'b1;
    for (int i = 1; i <= 4; i++) step(1'b1, 2'd0, PIXEL_W'(2048 + i), 1'b0);
    chk("post_reset_mask", W'(ulOutLaneMask), W'(4'hF));
    chk("post_reset_lane0", W'(ulOutData[PIXEL_W-1:0]), W'(2049));
    idle(3);
    drain();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
